// File: rtl/hsync_decoder.sv
// Horizontal timing decoder: measures line/sync/active widths, locks on repeats, recovers x.
// Optional error statistics enabled by defining HSYNC_DEC_STATS_EN.
module hsync_decoder #(
  parameter int CNT_WIDTH       = 12,
  parameter int LOCK_LINES      = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 resetn,
  input  logic                 hsync,
  input  logic                 h_blank,
  output logic [CNT_WIDTH-1:0] x_pos,
  output logic                 x_valid,
  output logic [CNT_WIDTH-1:0] line_total,
  output logic [CNT_WIDTH-1:0] sync_width,
  output logic [CNT_WIDTH-1:0] active_width,
  output logic                 locked,
  output logic                 line_strobe,
  output logic                 mismatch,
  output logic [7:0]           err_count
);

  typedef enum logic [1:0] {SEEK, MEASURE, CHECK, LOCKED} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [15:0]          LOCK_N  = 16'(LOCK_LINES);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t                 state_q, state_d;
  logic                   s_sync_q, s_sync_d, s_blank_q, s_blank_d;
  logic                   prev_sync_q, prev_blank_q;
  logic [CNT_WIDTH-1:0]   line_cnt_q, line_cnt_d, sync_cnt_q, sync_cnt_d, act_cnt_q, act_cnt_d;
  logic [15:0]            match_q, match_d;
  logic [CNT_WIDTH-1:0]   x_pos_q, x_pos_d, line_total_q, line_total_d;
  logic [CNT_WIDTH-1:0]   sync_width_q, sync_width_d, active_width_q, active_width_d;
  logic                   x_valid_q, x_valid_d, locked_q, locked_d;
  logic                   strobe_q, strobe_d, mismatch_q, mismatch_d;
  logic                   edge_det, diff, capture, sat_drop;

  always_comb begin
    s_sync_d  = SYNC_ACTIVE_LOW ? ~hsync : hsync;
    s_blank_d = h_blank;
    edge_det  = s_sync_q & ~prev_sync_q;
    sat_drop  = ~edge_det & (state_q != SEEK) & (line_cnt_q == CNT_MAX);
    diff      = (line_cnt_q != line_total_q) || (sync_cnt_q != sync_width_q) ||
                (act_cnt_q != active_width_q);

    if (edge_det) begin
      line_cnt_d = CNT_WIDTH'(1);
      sync_cnt_d = CNT_WIDTH'(1);
      act_cnt_d  = s_blank_q ? '0 : CNT_WIDTH'(1);
    end else begin
      line_cnt_d = sat_inc(line_cnt_q);
      sync_cnt_d = s_sync_q ? sat_inc(sync_cnt_q) : sync_cnt_q;
      act_cnt_d  = s_blank_q ? act_cnt_q : sat_inc(act_cnt_q);
    end

    state_d        = state_q;
    match_d        = match_q;
    locked_d       = locked_q;
    strobe_d       = 1'b0;
    mismatch_d     = 1'b0;
    capture        = 1'b0;
    line_total_d   = line_total_q;
    sync_width_d   = sync_width_q;
    active_width_d = active_width_q;

    // A leading edge takes priority over a simultaneous counter saturation.
    if (edge_det) begin
      strobe_d = (state_q != SEEK);
      case (state_q)
        SEEK:    state_d = MEASURE;
        MEASURE: begin
          capture = 1'b1;
          match_d = 16'd1;
          if (LOCK_LINES <= 1) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else begin
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (diff) begin
            mismatch_d = 1'b1;
            capture    = 1'b1;
            match_d    = 16'd1;
          end else begin
            match_d = match_q + 16'd1;
            if (match_d >= LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end
        end
        default: begin
          if (diff) begin
            mismatch_d = 1'b1;
            capture    = 1'b1;
            match_d    = 16'd1;
            locked_d   = 1'b0;
            state_d    = CHECK;
          end
        end
      endcase
    end else if (sat_drop) begin
      state_d        = SEEK;
      locked_d       = 1'b0;
      match_d        = '0;
      line_total_d   = '0;
      sync_width_d   = '0;
      active_width_d = '0;
    end

    if (capture) begin
      line_total_d   = line_cnt_q;
      sync_width_d   = sync_cnt_q;
      active_width_d = act_cnt_q;
    end

    // x restarts on the first active pixel and holds through blanking.
    x_pos_d = x_pos_q;
    if (!s_blank_q) x_pos_d = prev_blank_q ? '0 : sat_inc(x_pos_q);
    x_valid_d = locked_d & ~s_blank_q;
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_q        <= SEEK;
      s_sync_q       <= 1'b0;
      s_blank_q      <= 1'b1;
      prev_sync_q    <= 1'b0;
      prev_blank_q   <= 1'b1;
      line_cnt_q     <= '0;
      sync_cnt_q     <= '0;
      act_cnt_q      <= '0;
      match_q        <= '0;
      x_pos_q        <= '0;
      x_valid_q      <= 1'b0;
      line_total_q   <= '0;
      sync_width_q   <= '0;
      active_width_q <= '0;
      locked_q       <= 1'b0;
      strobe_q       <= 1'b0;
      mismatch_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_sync_q       <= s_sync_d;
      s_blank_q      <= s_blank_d;
      prev_sync_q    <= s_sync_q;
      prev_blank_q   <= s_blank_q;
      line_cnt_q     <= line_cnt_d;
      sync_cnt_q     <= sync_cnt_d;
      act_cnt_q      <= act_cnt_d;
      match_q        <= match_d;
      x_pos_q        <= x_pos_d;
      x_valid_q      <= x_valid_d;
      line_total_q   <= line_total_d;
      sync_width_q   <= sync_width_d;
      active_width_q <= active_width_d;
      locked_q       <= locked_d;
      strobe_q       <= strobe_d;
      mismatch_q     <= mismatch_d;
    end
  end

`ifdef HSYNC_DEC_STATS_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((mismatch_d || sat_drop) && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) err_q <= '0;
    else         err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign x_pos        = x_pos_q;
  assign x_valid      = x_valid_q;
  assign line_total   = line_total_q;
  assign sync_width   = sync_width_q;
  assign active_width = active_width_q;
  assign locked       = locked_q;
  assign line_strobe  = strobe_q;
  assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_hsync_decoder.sv
// Bench for hsync_decoder: generator-style stimulus (sync 2, back porch 2, active 8, front porch 2).
module tb_hsync_decoder;
  localparam int CW = 12;
`ifdef HSYNC_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0, hsync = 1'b1, h_blank = 1'b1, hsync_hi;
  logic [CW-1:0] x_pos, line_total, sync_width, active_width;
  logic x_valid, locked, line_strobe, mismatch;
  logic [7:0] err_count;
  logic [CW-1:0] hi_x_pos, hi_line_total, hi_sync_width, hi_active_width;
  logic hi_x_valid, hi_locked, hi_line_strobe, hi_mismatch;
  logic [7:0] hi_err_count;

  int checks = 0, failures = 0, mm_total = 0;

  typedef struct {logic v; logic st; logic [CW-1:0] x;} exp_t;
  exp_t exp_q[$];

  assign hsync_hi = ~hsync;

  hsync_decoder #(.CNT_WIDTH(CW), .LOCK_LINES(2), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clk_in(clk), .resetn(resetn), .hsync(hsync), .h_blank(h_blank),
    .x_pos(x_pos), .x_valid(x_valid), .line_total(line_total), .sync_width(sync_width),
    .active_width(active_width), .locked(locked), .line_strobe(line_strobe),
    .mismatch(mismatch), .err_count(err_count));

  hsync_decoder #(.CNT_WIDTH(CW), .LOCK_LINES(2), .SYNC_ACTIVE_LOW(1'b0)) dut_hi (
    .clk_in(clk), .resetn(resetn), .hsync(hsync_hi), .h_blank(h_blank),
    .x_pos(hi_x_pos), .x_valid(hi_x_valid), .line_total(hi_line_total),
    .sync_width(hi_sync_width), .active_width(hi_active_width), .locked(hi_locked),
    .line_strobe(hi_line_strobe), .mismatch(hi_mismatch), .err_count(hi_err_count));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mismatch) mm_total++;
  end

  function automatic logic pos_sync(input int p);
    return p < 2;
  endfunction

  function automatic logic pos_blank(input int p);
    return !(p >= 4 && p < 12);
  endfunction

  // Drives one cycle starting at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic s, input logic b);
    hsync   = ~s;
    h_blank = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic line_part(input int from, input int to);
    for (int p = from; p <= to; p++) cyc(pos_sync(p), pos_blank(p));
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    checks += 9;
    if (x_pos !== '0)        begin failures++; $display("FAIL reset_x_pos: got %0d want 0", x_pos); end
    if (x_valid !== 1'b0)    begin failures++; $display("FAIL reset_x_valid: got %b want 0", x_valid); end
    if (line_total !== '0)   begin failures++; $display("FAIL reset_line_total: got %0d want 0", line_total); end
    if (sync_width !== '0)   begin failures++; $display("FAIL reset_sync_width: got %0d want 0", sync_width); end
    if (active_width !== '0) begin failures++; $display("FAIL reset_active_width: got %0d want 0", active_width); end
    if (locked !== 1'b0)     begin failures++; $display("FAIL reset_locked: got %b want 0", locked); end
    if (line_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b want 0", line_strobe); end
    if (mismatch !== 1'b0)   begin failures++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
    if (err_count !== 8'd0)  begin failures++; $display("FAIL reset_err: got %0d want 0", err_count); end
    resetn = 1'b1;
  endtask

  task automatic test_lock;
    int mm0;
    mm0 = mm_total;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    line_part(0, 13);
    line_part(0, 13);
    line_part(0, 0);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL lock_early: got %b want 0", locked); end
    line_part(1, 1);
    checks += 4;
    if (locked !== 1'b1)            begin failures++; $display("FAIL lock_third_edge: got %b want 1", locked); end
    if (line_total !== 12'd14)      begin failures++; $display("FAIL lock_line_total: got %0d want 14", line_total); end
    if (sync_width !== 12'd2)       begin failures++; $display("FAIL lock_sync_width: got %0d want 2", sync_width); end
    if (active_width !== 12'd8)     begin failures++; $display("FAIL lock_active_width: got %0d want 8", active_width); end
    line_part(2, 13);
    line_part(0, 13);
    line_part(0, 13);
    checks += 2;
    if (locked !== 1'b1)        begin failures++; $display("FAIL lock_hold: got %b want 1", locked); end
    if (mm_total - mm0 != 0)    begin failures++; $display("FAIL lock_no_mismatch: got %0d pulses want 0", mm_total - mm0); end
  endtask

  task automatic test_x_pos;
    exp_t e, o;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 14; p++) begin
        e.v  = !pos_blank(p);
        e.st = (p == 0);
        e.x  = e.v ? CW'(p - 4) : '0;
        exp_q.push_back(e);
        cyc(pos_sync(p), pos_blank(p));
        if (exp_q.size() >= 2) begin
          o = exp_q.pop_front();
          checks += 2;
          if (x_valid !== o.v)      begin failures++; $display("FAIL xpos_valid: got %b want %b", x_valid, o.v); end
          if (line_strobe !== o.st) begin failures++; $display("FAIL xpos_strobe: got %b want %b", line_strobe, o.st); end
          if (o.v) begin
            checks++;
            if (x_pos !== o.x) begin failures++; $display("FAIL xpos_value: got %0d want %0d", x_pos, o.x); end
          end
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_mismatch;
    int mm0;
    mm0 = mm_total;
    for (int p = 0; p < 15; p++) cyc(pos_sync(p), pos_blank(p));
    line_part(0, 1);
    checks += 3;
    if (mm_total - mm0 != 1)   begin failures++; $display("FAIL mm_first_pulse: got %0d want 1", mm_total - mm0); end
    if (locked !== 1'b0)       begin failures++; $display("FAIL mm_lock_drop: got %b want 0", locked); end
    if (line_total !== 12'd15) begin failures++; $display("FAIL mm_recapture15: got %0d want 15", line_total); end
    line_part(2, 13);
    line_part(0, 1);
    checks += 3;
    if (mm_total - mm0 != 2)   begin failures++; $display("FAIL mm_second_pulse: got %0d want 2", mm_total - mm0); end
    if (locked !== 1'b0)       begin failures++; $display("FAIL mm_still_unlocked: got %b want 0", locked); end
    if (line_total !== 12'd14) begin failures++; $display("FAIL mm_recapture14: got %0d want 14", line_total); end
    line_part(2, 13);
    line_part(0, 1);
    checks += 3;
    if (locked !== 1'b1)       begin failures++; $display("FAIL mm_relock: got %b want 1", locked); end
    if (mm_total - mm0 != 2)   begin failures++; $display("FAIL mm_no_third: got %0d want 2", mm_total - mm0); end
    if (err_count !== (STATS ? 8'd2 : 8'd0))
      begin failures++; $display("FAIL mm_err_count: got %0d want %0d", err_count, STATS ? 2 : 0); end
    line_part(2, 13);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4110; i++) cyc(1'b0, 1'b1);
    checks += 5;
    if (locked !== 1'b0)     begin failures++; $display("FAIL sat_locked: got %b want 0", locked); end
    if (line_total !== '0)   begin failures++; $display("FAIL sat_line_total: got %0d want 0", line_total); end
    if (sync_width !== '0)   begin failures++; $display("FAIL sat_sync_width: got %0d want 0", sync_width); end
    if (active_width !== '0) begin failures++; $display("FAIL sat_active_width: got %0d want 0", active_width); end
    if (err_count !== (STATS ? 8'd3 : 8'd0))
      begin failures++; $display("FAIL sat_err_count: got %0d want %0d", err_count, STATS ? 3 : 0); end
    line_part(0, 13);
    line_part(0, 13);
    line_part(0, 1);
    checks += 2;
    if (locked !== 1'b1)       begin failures++; $display("FAIL sat_relock: got %b want 1", locked); end
    if (line_total !== 12'd14) begin failures++; $display("FAIL sat_relock_total: got %0d want 14", line_total); end
    line_part(2, 13);
  endtask

  task automatic test_async_reset;
    line_part(0, 5);
    #2 resetn = 1'b0;
    #1;
    checks += 5;
    if (locked !== 1'b0)     begin failures++; $display("FAIL areset_locked: got %b want 0", locked); end
    if (x_valid !== 1'b0)    begin failures++; $display("FAIL areset_x_valid: got %b want 0", x_valid); end
    if (x_pos !== '0)        begin failures++; $display("FAIL areset_x_pos: got %0d want 0", x_pos); end
    if (line_total !== '0)   begin failures++; $display("FAIL areset_line_total: got %0d want 0", line_total); end
    if (err_count !== 8'd0)  begin failures++; $display("FAIL areset_err: got %0d want 0", err_count); end
    @(negedge clk);
    resetn = 1'b1;
    line_part(7, 13);
    line_part(0, 13);
    line_part(0, 13);
    line_part(0, 0);
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL areset_early: got %b want 0", locked); end
    line_part(1, 1);
    checks += 2;
    if (locked !== 1'b1)       begin failures++; $display("FAIL areset_relock: got %b want 1", locked); end
    if (line_total !== 12'd14) begin failures++; $display("FAIL areset_total: got %0d want 14", line_total); end
    line_part(2, 13);
  endtask

  task automatic test_polarity;
    checks += 4;
    if (hi_locked !== 1'b1)        begin failures++; $display("FAIL pol_locked: got %b want 1", hi_locked); end
    if (hi_line_total !== 12'd14)  begin failures++; $display("FAIL pol_line_total: got %0d want 14", hi_line_total); end
    if (hi_sync_width !== 12'd2)   begin failures++; $display("FAIL pol_sync_width: got %0d want 2", hi_sync_width); end
    if (hi_active_width !== 12'd8) begin failures++; $display("FAIL pol_active_width: got %0d want 8", hi_active_width); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lock();
    test_x_pos();
    test_mismatch();
    test_saturation();
    test_async_reset();
    test_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
